// File: rtl/wta_pwm_multi.sv
// N-channel winner-take-all PWM generator: shared prescaler and period counter,
// shadow-buffered duty updates applied at period boundaries, hysteretic winner selection.
module wta_pwm_multi #(
  parameter int N_CH  = 4,
  parameter int W     = 8,
  parameter int PRE_W = 8,
  parameter int HYST  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [PRE_W-1:0]          prescale,
  input  logic                      mode,
  input  logic [N_CH*W-1:0]         duty_in,
  input  logic                      duty_valid,
  output logic                      duty_ready,
  output logic [N_CH-1:0]           pwm_out,
  output logic [$clog2(N_CH)-1:0]   winner_idx,
  output logic                      winner_valid,
  output logic                      period_tick
);

  localparam int IDX_W = $clog2(N_CH);

  logic [PRE_W-1:0] pre_cnt;
  logic [W-1:0]     cnt;
  logic [W-1:0]     active [N_CH];
  logic [W-1:0]     shadow [N_CH];
  logic             pending;
  logic             mode_l;

  logic             tick;
  logic             boundary;
  logic             accept;
  logic             apply;

  logic [IDX_W-1:0] max_idx;
  logic [W-1:0]     max_val;
  logic [W-1:0]     cur_val;
  logic [W:0]       thr;
  logic [IDX_W-1:0] next_idx;
  logic [W-1:0]     next_val;
  logic             next_valid;
  logic [N_CH-1:0]  pwm_next;

  // Handshake: a transfer happens on any cycle with duty_valid & duty_ready.
  // duty_ready stays low from the accept until the shadow set has been applied,
  // and is low throughout reset; duty_in/mode must be stable while valid is high.
  assign duty_ready = ~pending & ~rst;
  assign accept     = duty_valid & duty_ready;

  // Wrapping through all-ones guarantees a tick even if prescale drops below pre_cnt.
  assign tick     = en & ((pre_cnt == prescale) | (pre_cnt == '1));
  assign boundary = tick & (cnt == '1);
  assign apply    = pending & (boundary | ~en);

  // Winner evaluation always looks at the values about to become active (shadow).
  always_comb begin
    max_idx = '0;
    max_val = shadow[0];
    for (int i = 1; i < N_CH; i++) begin
      if (shadow[i] > max_val) begin
        max_val = shadow[i];
        max_idx = IDX_W'(i);
      end
    end

    cur_val = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (winner_idx == IDX_W'(i)) cur_val = shadow[i];
    end
    thr = {1'b0, cur_val} + (W+1)'(HYST);

    if (!winner_valid || mode) begin
      next_idx = max_idx;
    end else if ({1'b0, max_val} > thr) begin
      next_idx = max_idx;
    end else begin
      next_idx = winner_idx;
    end

    next_val = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (next_idx == IDX_W'(i)) next_val = shadow[i];
    end
    next_valid = (next_val != '0);
  end

  always_comb begin
    pwm_next = '0;
    for (int i = 0; i < N_CH; i++) begin
      pwm_next[i] = en & (cnt < active[i]) &
                    (mode_l | (winner_valid & (winner_idx == IDX_W'(i))));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt      <= '0;
      cnt          <= '0;
      pending      <= 1'b0;
      mode_l       <= 1'b0;
      winner_idx   <= '0;
      winner_valid <= 1'b0;
      period_tick  <= 1'b0;
      pwm_out      <= '0;
      for (int i = 0; i < N_CH; i++) begin
        active[i] <= '0;
        shadow[i] <= '0;
      end
    end else begin
      if (en) begin
        pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
        if (tick) cnt <= cnt + W'(1);
      end
      period_tick <= boundary;
      pwm_out     <= pwm_next;

      if (accept) begin
        for (int i = 0; i < N_CH; i++) shadow[i] <= duty_in[i*W +: W];
        pending <= 1'b1;
      end else if (apply) begin
        for (int i = 0; i < N_CH; i++) active[i] <= shadow[i];
        mode_l       <= mode;
        winner_idx   <= next_idx;
        winner_valid <= next_valid;
        pending      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wta_pwm_multi.sv
// Directed bench for wta_pwm_multi: WTA selection, hysteresis, ties, independent mode,
// prescaling, enable freeze and reset with a pending update.
module tb_wta_pwm_multi;

  localparam int N_CH  = 4;
  localparam int W     = 8;
  localparam int PRE_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [PRE_W-1:0]  prescale;
  logic              mode;
  logic [N_CH*W-1:0] duty_in;
  logic              duty_valid;
  logic              duty_ready;
  logic [N_CH-1:0]   pwm_out;
  logic [1:0]        winner_idx;
  logic              winner_valid;
  logic              period_tick;

  int total = 0;
  int bad   = 0;
  int hi [N_CH];
  int pt_cnt;

  wta_pwm_multi #(.N_CH(N_CH), .W(W), .PRE_W(PRE_W), .HYST(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .prescale     (prescale),
    .mode         (mode),
    .duty_in      (duty_in),
    .duty_valid   (duty_valid),
    .duty_ready   (duty_ready),
    .pwm_out      (pwm_out),
    .winner_idx   (winner_idx),
    .winner_valid (winner_valid),
    .period_tick  (period_tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_period(input int limit);
    int n = 0;
    do begin
      step();
      n++;
    end while (!period_tick && n < limit);
    check("period_tick_seen", {31'd0, period_tick}, 32'd1);
  endtask

  task automatic load(input logic [N_CH*W-1:0] d, input logic m);
    int n = 0;
    mode       = m;
    duty_in    = d;
    duty_valid = 1'b1;
    while (!duty_ready && n < 3000) begin
      step();
      n++;
    end
    check("ready_before_accept", {31'd0, duty_ready}, 32'd1);
    step();
    duty_valid = 1'b0;
    check("ready_drop", {31'd0, duty_ready}, 32'd0);
  endtask

  task automatic measure(input int len);
    for (int c = 0; c < N_CH; c++) hi[c] = 0;
    pt_cnt = 0;
    for (int k = 0; k < len; k++) begin
      step();
      for (int c = 0; c < N_CH; c++) hi[c] += int'(pwm_out[c]);
      pt_cnt += int'(period_tick);
    end
    check("period_tick_count", pt_cnt, 1);
    check("period_tick_last", {31'd0, period_tick}, 32'd1);
  endtask

  task automatic check_hi(input string tag, input int e0, input int e1, input int e2, input int e3);
    check({tag, "_ch0"}, hi[0], e0);
    check({tag, "_ch1"}, hi[1], e1);
    check({tag, "_ch2"}, hi[2], e2);
    check({tag, "_ch3"}, hi[3], e3);
  endtask

  initial begin
    int   n;
    logic frz_ok;

    rst        = 1'b1;
    en         = 1'b0;
    prescale   = '0;
    mode       = 1'b0;
    duty_in    = '0;
    duty_valid = 1'b0;
    step();
    step();
    check("rst_pwm", pwm_out, 0);
    check("rst_winner_idx", winner_idx, 0);
    check("rst_winner_valid", winner_valid, 0);
    check("rst_period_tick", period_tick, 0);
    check("rst_ready", duty_ready, 0);
    rst = 1'b0;
    en  = 1'b1;
    #1;
    check("ready_after_rst", duty_ready, 1);

    // WTA basic: channel 1 wins with 200
    load({8'd0, 8'd50, 8'd200, 8'd10}, 1'b0);
    wait_period(600);
    check("t1_winner_idx", winner_idx, 1);
    check("t1_winner_valid", winner_valid, 1);
    check("t1_ready_back", duty_ready, 1);
    measure(256);
    check_hi("t1", 0, 200, 0, 0);

    // Hysteresis: 203 and 204 do not beat 200+4, 205 does
    load({8'd0, 8'd203, 8'd200, 8'd10}, 1'b0);
    wait_period(600);
    check("hyst203_idx", winner_idx, 1);
    measure(256);
    check_hi("hyst203", 0, 200, 0, 0);
    load({8'd0, 8'd204, 8'd200, 8'd10}, 1'b0);
    wait_period(600);
    check("hyst204_idx", winner_idx, 1);
    load({8'd0, 8'd205, 8'd200, 8'd10}, 1'b0);
    wait_period(600);
    check("hyst205_idx", winner_idx, 2);
    measure(256);
    check_hi("hyst205", 0, 0, 205, 0);

    // Tie resolves to lowest index, then all-zero invalidates
    load({8'd0, 8'd0, 8'd80, 8'd80}, 1'b0);
    wait_period(600);
    check("tie_idx", winner_idx, 0);
    check("tie_valid", winner_valid, 1);
    measure(256);
    check_hi("tie", 80, 0, 0, 0);
    load('0, 1'b0);
    wait_period(600);
    check("zero_valid", winner_valid, 0);
    check("zero_idx", winner_idx, 0);
    measure(256);
    check_hi("zero", 0, 0, 0, 0);

    // Independent mode
    load({8'd255, 8'd192, 8'd128, 8'd64}, 1'b1);
    wait_period(600);
    check("ind_idx", winner_idx, 3);
    check("ind_valid", winner_valid, 1);
    measure(256);
    check_hi("ind", 64, 128, 192, 255);

    // Prescale 3: tick every 4 cycles, period 1024 cycles
    prescale = 8'd3;
    wait_period(3000);
    measure(1024);
    check_hi("pre3", 256, 512, 768, 1020);

    // Enable freeze mid-period with an en=0 update (mode back to WTA)
    for (int k = 0; k < 100; k++) step();
    check("run_pwm_mid", pwm_out, 4'b1111);
    en = 1'b0;
    step();
    check("frz_pwm_low", pwm_out, 0);
    load({8'd255, 8'd192, 8'd128, 8'd64}, 1'b0);
    step();
    check("en0_apply_ready", duty_ready, 1);
    check("en0_apply_idx", winner_idx, 3);
    check("en0_apply_valid", winner_valid, 1);
    frz_ok = 1'b1;
    for (int k = 0; k < 47; k++) begin
      step();
      if (pwm_out !== '0 || period_tick !== 1'b0) frz_ok = 1'b0;
    end
    check("frz_quiet", frz_ok, 1);
    en = 1'b1;
    step();
    check("resume_pwm", pwm_out, 4'b1000);
    n = 1;
    while (!period_tick && n < 3000) begin
      step();
      n++;
    end
    check("resume_cycles_to_wrap", n, 924);

    // Reset while an update is pending
    prescale = 8'd0;
    load({8'd40, 8'd30, 8'd20, 8'd10}, 1'b0);
    for (int k = 0; k < 10; k++) step();
    rst = 1'b1;
    #1;
    check("rst2_ready_comb", duty_ready, 0);
    step();
    check("rst2_pwm", pwm_out, 0);
    check("rst2_winner_idx", winner_idx, 0);
    check("rst2_winner_valid", winner_valid, 0);
    check("rst2_period_tick", period_tick, 0);
    check("rst2_ready", duty_ready, 0);
    step();
    rst = 1'b0;
    #1;
    check("rst2_ready_after", duty_ready, 1);
    wait_period(600);
    check("rst2_no_apply_valid", winner_valid, 0);
    check("rst2_no_pending", duty_ready, 1);
    measure(256);
    check_hi("rst2", 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
